period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 131 +++++++++++++
 tb/tb_period_meter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period meter: measures the slow_in rising-edge interval in clk_in cycles and
// reports lock once consecutive periods agree. Optional macro: PERIOD_METER_GLITCH_FILTER_EN.
module period_meter #(
  parameter int CNT_W  = 21,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  localparam int              MC_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_N - 1);
  localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);

  logic s1, s2, s3, rise;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  // A rise needs two synchronized highs after a low, so one-cycle glitches vanish.
  logic s4;
  assign rise = s2 & s3 & ~s4;

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) s4 <= 1'b0;
    else        s4 <= s3;
`else
  assign rise = s2 & ~s3;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= slow_in;
      s2   <= s1;
      s3   <= s2;
      tick <= rise;
    end
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, period_n;
  logic [MC_W-1:0]  mc, mc_n, mc_inc;
  logic             has_prev, prev_n, pv_n, match;
  logic [CNT_W:0]   diff;

  // Widened by one bit so the absolute difference can never wrap.
  always_comb begin
    if ({1'b0, cnt} >= {1'b0, period}) diff = {1'b0, cnt} - {1'b0, period};
    else                               diff = {1'b0, period} - {1'b0, cnt};
    match  = has_prev && (diff <= TOL_X);
    mc_inc = (mc >= MC_LOCK) ? mc : mc + MC_W'(1);
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mc_n     = mc;
    prev_n   = has_prev;
    period_n = period;
    pv_n     = 1'b0;
    overflow = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          cnt_n   = CNT_W'(1);
          mc_n    = '0;
          prev_n  = 1'b0;
          state_n = MEASURE;
        end
      end
      default: begin
        // A tick on the saturation cycle wins: the interval is reported as CNT_MAX.
        if (tick) begin
          period_n = cnt;
          pv_n     = 1'b1;
          cnt_n    = CNT_W'(1);
          prev_n   = 1'b1;
          if (match) begin
            mc_n    = mc_inc;
            state_n = (mc_inc >= MC_LOCK) ? LOCKED : MEASURE;
          end else begin
            mc_n    = '0;
            state_n = MEASURE;
          end
        end else if (cnt == CNT_MAX) begin
          overflow = 1'b1;
          cnt_n    = '0;
          mc_n     = '0;
          prev_n   = 1'b0;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      mc           <= '0;
      has_prev     <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      mc           <= mc_n;
      has_prev     <= prev_n;
      period       <= period_n;
      period_valid <= pv_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_period_meter.sv
// Directed-vector bench for period_meter: lock/unlock table, reset abort,
// glitch/latency corners and saturation on a narrow (CNT_W=6) instance.
module tb_period_meter;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  localparam int LAT = 4;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_TICKS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow = 1'b0, slow_s = 1'b0;
  logic        tick, pv, locked, ov;
  logic [20:0] period;
  logic        s_tick, s_pv, s_locked, s_ov;
  logic [5:0]  s_period;

  always #5 clk = ~clk;

  period_meter u_dut (
    .clk_in(clk), .rst_n(rst_n), .slow_in(slow), .tick(tick), .period(period),
    .period_valid(pv), .locked(locked), .overflow(ov)
  );

  period_meter #(.CNT_W(6)) u_small (
    .clk_in(clk), .rst_n(rst_n), .slow_in(slow_s), .tick(s_tick), .period(s_period),
    .period_valid(s_pv), .locked(s_locked), .overflow(s_ov)
  );

  int total = 0, bad = 0;
  int cyc = 0;
  int n_tick = 0, n_pv = 0, last_per = 0, last_lock = 0;
  int s_ntick = 0, s_npv = 0, s_nov = 0, s_last_per = 0, s_tick_cyc = 0, s_ov_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick) n_tick++;
    if (pv) begin
      n_pv++;
      last_per  = int'(period);
      last_lock = int'(locked);
    end
    if (s_tick) begin
      s_ntick++;
      s_tick_cyc = cyc;
    end
    if (s_pv) begin
      s_npv++;
      s_last_per = int'(s_period);
    end
    if (s_ov) begin
      s_nov++;
      s_ov_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic wave(input int p);
    slow = 1'b1;
    step(p / 2);
    slow = 1'b0;
    step(p - p / 2);
  endtask

  typedef struct {
    int rst;
    int p;
    int exp_pv;
    int exp_per;
    int exp_lock;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int pv0, t0, first_n, ov0;
    // each entry drives one slow_in cycle; its rising edge closes the previous entry's interval
    tbl = '{
      '{0, 32, 0,  0, 0}, '{0, 32, 1, 32, 0}, '{0, 32, 1, 32, 0}, '{0, 32, 1, 32, 0},
      '{0, 32, 1, 32, 1}, '{0, 40, 1, 32, 1}, '{0, 32, 1, 40, 0}, '{0, 32, 1, 32, 0},
      '{0, 32, 1, 32, 0}, '{0, 32, 1, 32, 0}, '{0, 33, 1, 32, 1}, '{0, 32, 1, 33, 1},
      '{0, 31, 1, 32, 1}, '{0, 32, 1, 31, 1}, '{0, 34, 1, 32, 1}, '{0, 32, 1, 34, 0},
      '{1, 32, 0,  0, 0}, '{0, 33, 1, 32, 0}, '{0, 32, 1, 33, 0}, '{0, 31, 1, 32, 0},
      '{0, 32, 1, 31, 1}, '{0, 34, 1, 32, 1}, '{0, 32, 1, 34, 0}
    };

    #2;
    chk("rst_tick", int'(tick), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_pv", int'(pv), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(ov), 0);
    step(2);
    rst_n = 1'b1;
    step(4);

    t0 = n_tick;
    slow = 1'b1;
    step(1);
    slow = 1'b0;
    step(8);
    chk("glitch_ticks", n_tick - t0, GLITCH_TICKS);

    do_reset();
    first_n = 0;
    slow = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #2;
      if (tick && first_n == 0) first_n = n;
    end
    slow = 1'b0;
    chk("tick_latency", first_n, LAT);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      if (tbl[i].rst != 0) do_reset();
      pv0 = n_pv;
      wave(tbl[i].p);
      chk($sformatf("vec%0d_pv", i), n_pv - pv0, tbl[i].exp_pv);
      if (tbl[i].exp_pv != 0) begin
        chk($sformatf("vec%0d_period", i), last_per, tbl[i].exp_per);
        chk($sformatf("vec%0d_locked", i), last_lock, tbl[i].exp_lock);
      end
    end

    // reset pulse mid-interval while locked
    do_reset();
    repeat (5) wave(32);
    chk("pre_abort_locked", int'(locked), 1);
    slow = 1'b1;
    step(16);
    slow = 1'b0;
    step(10);
    rst_n = 1'b0;
    #1;
    chk("abort_tick", int'(tick), 0);
    chk("abort_period", int'(period), 0);
    chk("abort_pv", int'(pv), 0);
    chk("abort_locked", int'(locked), 0);
    chk("abort_overflow", int'(ov), 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    pv0 = n_pv;
    wave(32);
    chk("post_abort_first_pv", n_pv - pv0, 0);
    wave(32);
    chk("post_abort_second_pv", n_pv - pv0, 1);
    chk("post_abort_period", last_per, 32);

    // narrow counter: overflow after 63 idle cycles, then a tick landing on saturation
    pv0 = s_npv;
    ov0 = s_nov;
    slow_s = 1'b1;
    step(10);
    slow_s = 1'b0;
    step(10);
    slow_s = 1'b1;
    step(10);
    slow_s = 1'b0;
    step(80);
    chk("small_pv", s_npv - pv0, 1);
    chk("small_period", s_last_per, 20);
    chk("small_ov_count", s_nov - ov0, 1);
    chk("small_ov_delay", s_ov_cyc - s_tick_cyc, 63);
    chk("small_period_held", int'(s_period), 20);
    chk("small_locked", int'(s_locked), 0);
    pv0 = s_npv;
    ov0 = s_nov;
    slow_s = 1'b1;
    step(10);
    slow_s = 1'b0;
    step(53);
    chk("small_idle_tick_pv", s_npv - pv0, 0);
    slow_s = 1'b1;
    step(10);
    slow_s = 1'b0;
    step(10);
    chk("small_sat_pv", s_npv - pv0, 1);
    chk("small_sat_period", s_last_per, 63);
    chk("small_sat_no_ov", s_nov - ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
